// File: rtl/fir_mc_pkg.sv
// Shared types and elaboration helpers for the multi-channel decimating FIR.
package fir_mc_pkg;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r++;
        end
        return r;
    endfunction

    function automatic int idx_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    function automatic int acc_w(input int dw, input int cw, input int taps);
        return dw + cw + clog2(taps);
    endfunction

    function automatic int rst_coef(input int k);
        return (k == 0) ? 1 : 0;
    endfunction

endpackage

// File: rtl/fir_mc_mac.sv
// Time-shared MAC: registered signed product feeding an accumulator.
module fir_mc_mac
    import fir_mc_pkg::*;
#(
    parameter int A_W   = 16,
    parameter int B_W   = 12,
    parameter int ACC_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    first,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] sum
);

    localparam int P_W = A_W + B_W;

    logic signed [P_W-1:0]   prod_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] prod_ext;
    logic                    vld_q;
    logic                    first_q;

    assign prod_ext = ACC_W'(prod_q);
    // A product tagged first restarts the running sum for a new channel.
    assign sum = first_q ? prod_ext : acc_q + prod_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q  <= '0;
            acc_q   <= '0;
            vld_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            vld_q <= en;
            if (en) begin
                prod_q  <= P_W'(a) * P_W'(b);
                first_q <= first;
            end
            if (vld_q) acc_q <= sum;
        end
    end

endmodule

// File: rtl/fir_filter_mc.sv
// Multi-channel decimating FIR with one shared coefficient set
// and a single time-multiplexed MAC.
module fir_filter_mc
    import fir_mc_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 12,
    parameter int TAPS   = 16,
    parameter int CH     = 2,
    parameter int DECIM  = 1,
    parameter int ACC_W  = acc_w(DATA_W, COEF_W, TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH*DATA_W-1:0]     in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CH*ACC_W-1:0]      out_data,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_wdata,
    output logic                     coef_ready
);

    localparam int N     = TAPS * CH;
    localparam int CNT_W = idx_w(N + 2);
    localparam int KW    = idx_w(TAPS);
    localparam int CW    = idx_w(CH);
    localparam int PHW   = idx_w(DECIM);
    localparam int AW    = $clog2(TAPS);
    localparam bit POW2  = ((1 << AW) == TAPS);

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic [KW-1:0]             k_q;
    logic [CW-1:0]             c_q;
    logic [PHW-1:0]            phase;
    logic signed [DATA_W-1:0]  dl [CH][TAPS];
    logic signed [COEF_W-1:0]  coef [TAPS];
    logic signed [ACC_W-1:0]   res [CH];
    logic signed [ACC_W-1:0]   sum;
    logic                      last_q;
    logic [CW-1:0]             cl_q;
    logic                      idle;
    logic                      accept;
    logic                      iss;
    logic                      addr_ok;

    assign idle       = (state == IDLE) && !rst;
    assign in_ready   = idle;
    assign coef_ready = idle;
    assign accept     = in_valid && idle;
    assign iss        = (state == MAC) && (cnt < CNT_W'(N));
    assign addr_ok    = POW2 ? 1'b1 : (int'(coef_addr) < TAPS);

    for (genvar g = 0; g < CH; g++) begin : g_out
        assign out_data[g*ACC_W +: ACC_W] = res[g];
    end

    fir_mc_mac #(
        .A_W   (DATA_W),
        .B_W   (COEF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .en    (iss),
        .first (k_q == '0),
        .a     (dl[c_q][k_q]),
        .b     (coef[k_q]),
        .sum   (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            k_q       <= '0;
            c_q       <= '0;
            phase     <= '0;
            out_valid <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                coef[k] <= COEF_W'(rst_coef(k));
            end
            for (int c = 0; c < CH; c++) begin
                for (int k = 0; k < TAPS; k++) dl[c][k] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (coef_we && addr_ok) coef[coef_addr] <= coef_wdata;
                    if (accept) begin
                        for (int c = 0; c < CH; c++) begin
                            dl[c][0] <= in_data[c*DATA_W +: DATA_W];
                            for (int k = 1; k < TAPS; k++) dl[c][k] <= dl[c][k-1];
                        end
                        if (phase == PHW'(DECIM - 1)) begin
                            phase <= '0;
                            state <= MAC;
                            cnt   <= '0;
                            k_q   <= '0;
                            c_q   <= '0;
                        end else begin
                            phase <= phase + 1'b1;
                        end
                    end
                end
                MAC: begin
                    cnt <= cnt + 1'b1;
                    if (iss) begin
                        if (k_q == KW'(TAPS - 1)) begin
                            k_q <= '0;
                            c_q <= c_q + 1'b1;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                    // One drain cycle for the product register, one to publish.
                    if (cnt == CNT_W'(N + 1)) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b0;
            cl_q   <= '0;
            for (int c = 0; c < CH; c++) res[c] <= '0;
        end else begin
            last_q <= iss && (k_q == KW'(TAPS - 1));
            cl_q   <= c_q;
            if (last_q) res[cl_q] <= sum;
        end
    end

endmodule

// File: tb/tb_fir_filter_mc.sv
// Directed bench for fir_filter_mc: default build plus a DECIM=4 build.
module tb_fir_filter_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [31:0] a_in_data = '0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b0;
    logic [63:0] a_out_data;
    logic        a_coef_we = 1'b0;
    logic [3:0]  a_coef_addr = '0;
    logic [11:0] a_coef_wdata = '0;
    logic        a_coef_ready;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [31:0] b_in_data = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b0;
    logic [63:0] b_out_data;
    logic        b_coef_ready;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fir_filter_mc u_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (a_in_valid),
        .in_ready   (a_in_ready),
        .in_data    (a_in_data),
        .out_valid  (a_out_valid),
        .out_ready  (a_out_ready),
        .out_data   (a_out_data),
        .coef_we    (a_coef_we),
        .coef_addr  (a_coef_addr),
        .coef_wdata (a_coef_wdata),
        .coef_ready (a_coef_ready)
    );

    fir_filter_mc #(.DECIM(4)) u_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (b_in_valid),
        .in_ready   (b_in_ready),
        .in_data    (b_in_data),
        .out_valid  (b_out_valid),
        .out_ready  (b_out_ready),
        .out_data   (b_out_data),
        .coef_we    (1'b0),
        .coef_addr  (4'd0),
        .coef_wdata (12'd0),
        .coef_ready (b_coef_ready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic push(input bit sel, input logic [15:0] d0, input logic [15:0] d1);
        int n = 0;
        while (!(sel ? b_in_ready : a_in_ready) && n < 200) begin
            tick();
            n++;
        end
        if (!(sel ? b_in_ready : a_in_ready)) begin
            n_cmp++;
            n_err++;
            $display("FAIL push_timeout in_ready=0 want 1");
        end
        if (sel) begin
            b_in_data = {d1, d0};
            b_in_valid = 1'b1;
        end else begin
            a_in_data = {d1, d0};
            a_in_valid = 1'b1;
        end
        tick();
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
    endtask

    task automatic wait_valid(input bit sel, output int lat);
        lat = 0;
        while (!(sel ? b_out_valid : a_out_valid) && lat < 200) begin
            tick();
            lat++;
        end
        if (!(sel ? b_out_valid : a_out_valid)) begin
            n_cmp++;
            n_err++;
            $display("FAIL out_timeout out_valid=0 want 1");
        end
    endtask

    task automatic pull(input bit sel, output int r0, output int r1, output int lat);
        wait_valid(sel, lat);
        r0 = sel ? b_out_data[31:0] : a_out_data[31:0];
        r1 = sel ? b_out_data[63:32] : a_out_data[63:32];
        a_out_ready = !sel;
        b_out_ready = sel;
        tick();
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
    endtask

    task automatic wr_coef(input logic [3:0] addr, input logic [11:0] val);
        a_coef_addr = addr;
        a_coef_wdata = val;
        a_coef_we = 1'b1;
        tick();
        a_coef_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (a_in_ready !== 1'b0 || a_coef_ready !== 1'b0 || a_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_flags got %b%b%b want 000", a_in_ready, a_coef_ready, a_out_valid);
        end
        n_cmp++;
        if (a_out_data !== 64'd0) begin
            n_err++;
            $display("FAIL rst_data got %h want 0", a_out_data);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (a_in_ready !== 1'b1 || a_coef_ready !== 1'b1) begin
            n_err++;
            $display("FAIL post_rst_ready got %b%b want 11", a_in_ready, a_coef_ready);
        end
    endtask

    task automatic test_identity();
        int r0, r1, lat;
        push(1'b0, 16'd100, -16'sd5);
        pull(1'b0, r0, r1, lat);
        n_cmp++;
        if (lat !== 34) begin
            n_err++;
            $display("FAIL id_latency got %0d want 34", lat);
        end
        n_cmp++;
        if (r0 !== 100 || r1 !== -5) begin
            n_err++;
            $display("FAIL id_data got %0d,%0d want 100,-5", r0, r1);
        end
        n_cmp++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL id_return got rdy=%b vld=%b want 1,0", a_in_ready, a_out_valid);
        end
    endtask

    task automatic test_boxcar();
        int r0, r1, lat;
        do_reset();
        for (int k = 0; k < 16; k++) wr_coef(4'(k), 12'd1);
        for (int i = 0; i < 21; i++) begin
            push(1'b0, (i == 0) ? 16'd1000 : 16'd0, 16'd0);
            pull(1'b0, r0, r1, lat);
            n_cmp++;
            if (r0 !== ((i < 16) ? 1000 : 0) || r1 !== 0) begin
                n_err++;
                $display("FAIL boxcar_%0d got %0d,%0d want %0d,0", i, r0, r1, (i < 16) ? 1000 : 0);
            end
        end
    endtask

    task automatic test_extremes();
        int r0, r1, lat;
        do_reset();
        for (int k = 0; k < 16; k++) wr_coef(4'(k), 12'h800);
        for (int i = 0; i < 16; i++) begin
            push(1'b0, 16'h8000, 16'h8000);
            pull(1'b0, r0, r1, lat);
            if (i == 0) begin
                n_cmp++;
                if (r0 !== 67108864 || r1 !== 67108864) begin
                    n_err++;
                    $display("FAIL ext_first got %0d,%0d want 67108864", r0, r1);
                end
            end
        end
        n_cmp++;
        if (r0 !== 1073741824 || r1 !== 1073741824) begin
            n_err++;
            $display("FAIL ext_full got %0d,%0d want 1073741824", r0, r1);
        end
    endtask

    task automatic test_decim();
        int r0, r1, lat;
        int extra = 0;
        for (int v = 1; v <= 8; v++) begin
            push(1'b1, 16'(v), 16'(-v));
            n_cmp++;
            if (b_in_ready !== ((v % 4) != 0)) begin
                n_err++;
                $display("FAIL decim_rdy_%0d got %b want %b", v, b_in_ready, (v % 4) != 0);
            end
            if (v % 4 == 0) begin
                pull(1'b1, r0, r1, lat);
                n_cmp++;
                if (r0 !== v || r1 !== -v || lat !== 34) begin
                    n_err++;
                    $display("FAIL decim_out_%0d got %0d,%0d lat %0d want %0d,%0d lat 34", v, r0, r1, lat, v, -v);
                end
            end
        end
        for (int i = 0; i < 50; i++) begin
            if (b_out_valid) extra++;
            tick();
        end
        n_cmp++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL decim_extra got %0d valid cycles want 0", extra);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [63:0] snap;
        do_reset();
        push(1'b0, 16'd7, -16'sd9);
        wait_valid(1'b0, lat);
        snap = a_out_data;
        n_cmp++;
        if (snap !== {32'hFFFF_FFF7, 32'd7}) begin
            n_err++;
            $display("FAIL bp_data got %h want fffffff700000007", snap);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_cmp++;
            if (a_out_valid !== 1'b1 || a_out_data !== snap || a_in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold_%0d got vld=%b rdy=%b data=%h want 1,0,%h", i, a_out_valid, a_in_ready, a_out_data, snap);
            end
        end
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        n_cmp++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release got vld=%b rdy=%b want 0,1", a_out_valid, a_in_ready);
        end
    endtask

    task automatic test_coef_mac_and_abort();
        int r0, r1, lat;
        int seen = 0;
        do_reset();
        wr_coef(4'd0, 12'd2);
        push(1'b0, 16'd10, 16'd20);
        a_coef_addr = 4'd0;
        a_coef_wdata = 12'd5;
        a_coef_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (a_coef_ready !== 1'b0) begin
                n_err++;
                $display("FAIL mac_coef_ready got %b want 0", a_coef_ready);
            end
            tick();
        end
        a_coef_we = 1'b0;
        pull(1'b0, r0, r1, lat);
        n_cmp++;
        if (r0 !== 20 || r1 !== 40) begin
            n_err++;
            $display("FAIL mac_we_now got %0d,%0d want 20,40", r0, r1);
        end
        push(1'b0, 16'd3, 16'd4);
        pull(1'b0, r0, r1, lat);
        n_cmp++;
        if (r0 !== 6 || r1 !== 8) begin
            n_err++;
            $display("FAIL mac_we_next got %0d,%0d want 6,8", r0, r1);
        end
        push(1'b0, 16'd11, 16'd12);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (a_out_valid) seen++;
            tick();
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL abort_out got %0d valid cycles want 0", seen);
        end
        push(1'b0, 16'd13, -16'sd14);
        pull(1'b0, r0, r1, lat);
        n_cmp++;
        if (r0 !== 13 || r1 !== -14) begin
            n_err++;
            $display("FAIL abort_next got %0d,%0d want 13,-14", r0, r1);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_decim();
        test_boxcar();
        test_extremes();
        test_backpressure();
        test_coef_mac_and_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
